// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one wide data-memory port between two cache-side
// requesters, holding the grant while the owner keeps enable high, with a no-ack watchdog.
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 256,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [1:0]        grant_o,
  output logic              timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WD_MAX = CNT_W'(TIMEOUT);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]       state;
  logic             owner;
  logic             last;
  logic [CNT_W-1:0] wd_cnt;

  logic own_en;
  logic any_req;
  logic pick;

  assign own_en  = owner ? m1_enable_i : m0_enable_i;
  assign any_req = m0_enable_i | m1_enable_i;
  // On a tie the port that did not win last time goes next.
  assign pick    = (m0_enable_i & m1_enable_i) ? ~last : m1_enable_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      wd_cnt    <= '0;
      timeout_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (any_req) begin
            owner <= pick;
            last  <= pick;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!own_en)
            state <= IDLE;
          // Watchdog only observes; it never forces a release.
          if (mem_ack_i) begin
            wd_cnt <= '0;
          end else if (wd_cnt != WD_MAX) begin
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt == WD_MAX - 1'b1)
              timeout_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    m0_ack_o     = 1'b0;
    m1_ack_o     = 1'b0;
    grant_o      = 2'b00;
    if (state == BUSY) begin
      if (owner) begin
        mem_enable_o = m1_enable_i;
        mem_write_o  = m1_write_i;
        mem_addr_o   = m1_addr_i;
        mem_data_o   = m1_data_i;
        m1_ack_o     = mem_ack_i;
        grant_o      = 2'b10;
      end else begin
        mem_enable_o = m0_enable_i;
        mem_write_o  = m0_write_i;
        mem_addr_o   = m0_addr_i;
        mem_data_o   = m0_data_i;
        m0_ack_o     = mem_ack_i;
        grant_o      = 2'b01;
      end
    end
  end

  assign m0_data_o = mem_data_i;
  assign m1_data_o = mem_data_i;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: grant, tie, locking, watchdog, async reset, stray ack.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_en = 0, m0_wr = 0, m1_en = 0, m1_wr = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdat = '0, m1_wdat = '0;
  logic [DW-1:0] m0_rdat, m1_rdat;
  logic          m0_ack, m1_ack;
  logic          mem_en, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdat;
  logic [DW-1:0] mem_rdat = '0;
  logic          mem_ack = 0;
  logic [1:0]    grant;
  logic          tmo;

  int checks = 0;
  int errors = 0;

  localparam logic [DW-1:0] PAT_AB = {32{8'hAB}};
  localparam logic [DW-1:0] PAT_D1 = {8{32'hDEAD_0001}};
  localparam logic [DW-1:0] PAT_D2 = {8{32'h5A5A_0002}};

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_enable_i(m0_en), .m0_write_i(m0_wr), .m0_addr_i(m0_addr), .m0_data_i(m0_wdat),
    .m0_data_o(m0_rdat), .m0_ack_o(m0_ack),
    .m1_enable_i(m1_en), .m1_write_i(m1_wr), .m1_addr_i(m1_addr), .m1_data_i(m1_wdat),
    .m1_data_o(m1_rdat), .m1_ack_o(m1_ack),
    .mem_enable_o(mem_en), .mem_write_o(mem_wr), .mem_addr_o(mem_addr), .mem_data_o(mem_wdat),
    .mem_data_i(mem_rdat), .mem_ack_i(mem_ack),
    .grant_o(grant), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    m0_addr = 32'h1234; m0_wdat = PAT_D1; m0_wr = 1;
    #3;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b exp 00", grant); end
    checks++; if (mem_en !== 1'b0 || mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_ctl: en %b wr %b exp 0 0", mem_en, mem_wr); end
    checks++; if (mem_addr !== '0 || mem_wdat !== '0) begin errors++; $display("FAIL reset_mem_bus: addr %h exp 0", mem_addr); end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b exp 0", tmo); end
    tick(); rst = 0; m0_addr = '0; m0_wdat = '0; m0_wr = 0;
    tick(); #1;
    checks++; if (mem_addr !== '0 || grant !== 2'b00) begin errors++; $display("FAIL idle_bus: addr %h grant %b exp 0 00", mem_addr, grant); end
  endtask

  task automatic test_tie();
    tick(); m0_en = 1; m1_en = 1; m1_addr = 32'h0000_0800;
    tick(); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tie_first: got %b exp 01", grant); end
    tick(); m0_en = 0; #1;
    tick(); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie_dead_cycle: got %b exp 00", grant); end
    tick(); #1;
    checks++; if (grant !== 2'b10 || mem_addr !== 32'h800) begin errors++; $display("FAIL tie_second: grant %b addr %h exp 10 800", grant, mem_addr); end
    tick(); m1_en = 0;
    tick(); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie_release1: got %b exp 00", grant); end
    m0_en = 1; m1_en = 1;
    tick(); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tie_next: got %b exp 01", grant); end
    m0_en = 0; m1_en = 0; m1_addr = '0;
    tick(); tick();
  endtask

  task automatic test_single_read();
    m0_en = 1; m0_wr = 0; m0_addr = 32'h0000_0420; #1;
    checks++; if (grant !== 2'b00 || mem_en !== 1'b0) begin errors++; $display("FAIL read_pre: grant %b en %b exp 00 0", grant, mem_en); end
    tick(); #1;
    checks++; if (grant !== 2'b01 || mem_en !== 1'b1 || mem_wr !== 1'b0) begin errors++; $display("FAIL read_grant: grant %b en %b wr %b exp 01 1 0", grant, mem_en, mem_wr); end
    checks++; if (mem_addr !== 32'h420) begin errors++; $display("FAIL read_addr: got %h exp 420", mem_addr); end
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL read_early_ack: got %b exp 0", m0_ack); end
    tick(); tick();
    tick(); mem_ack = 1; mem_rdat = PAT_AB; #1;
    checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin errors++; $display("FAIL read_ack: m0 %b m1 %b exp 1 0", m0_ack, m1_ack); end
    checks++; if (m0_rdat !== PAT_AB) begin errors++; $display("FAIL read_data: got %h exp %h", m0_rdat, PAT_AB); end
    tick(); mem_ack = 0; m0_en = 0; #1;
    checks++; if (mem_en !== 1'b0 || grant !== 2'b01 || m0_ack !== 1'b0) begin errors++; $display("FAIL read_release: en %b grant %b ack %b exp 0 01 0", mem_en, grant, m0_ack); end
    tick(); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL read_idle: got %b exp 00", grant); end
    m0_addr = '0;
  endtask

  task automatic test_locked();
    m0_en = 1; m0_wr = 1; m0_addr = 32'h0000_1400; m0_wdat = PAT_D1;
    tick(); #1;
    checks++; if (grant !== 2'b01 || mem_wr !== 1'b1 || mem_addr !== 32'h1400 || mem_wdat !== PAT_D1) begin errors++; $display("FAIL lock_wb: grant %b wr %b addr %h exp 01 1 1400", grant, mem_wr, mem_addr); end
    m1_en = 1; m1_addr = 32'h0000_9000;
    tick(); mem_ack = 1; #1;
    checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin errors++; $display("FAIL lock_wb_ack: m0 %b m1 %b exp 1 0", m0_ack, m1_ack); end
    tick(); mem_ack = 0; m0_wr = 0; m0_addr = 32'h0000_0400; #1;
    checks++; if (grant !== 2'b01 || mem_addr !== 32'h400 || mem_wr !== 1'b0) begin errors++; $display("FAIL lock_refill: grant %b addr %h wr %b exp 01 400 0", grant, mem_addr, mem_wr); end
    tick(); mem_ack = 1; mem_rdat = PAT_D2; #1;
    checks++; if (m0_ack !== 1'b1 || m0_rdat !== PAT_D2 || m1_ack !== 1'b0 || grant !== 2'b01) begin errors++; $display("FAIL lock_refill_ack: m0 %b m1 %b grant %b exp 1 0 01", m0_ack, m1_ack, grant); end
    tick(); mem_ack = 0; m0_en = 0; #1;
    checks++; if (grant !== 2'b01 || mem_en !== 1'b0) begin errors++; $display("FAIL lock_release: grant %b en %b exp 01 0", grant, mem_en); end
    tick(); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL lock_dead: got %b exp 00", grant); end
    tick(); #1;
    checks++; if (grant !== 2'b10 || mem_addr !== 32'h9000 || m1_ack !== 1'b0) begin errors++; $display("FAIL lock_waiter: grant %b addr %h exp 10 9000", grant, mem_addr); end
    m1_en = 0; m0_addr = '0; m0_wdat = '0; m1_addr = '0;
    tick(); tick();
  endtask

  task automatic test_stray_ack();
    mem_ack = 1; mem_rdat = PAT_D1; #1;
    checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL stray_ack: m0 %b m1 %b grant %b exp 0 0 00", m0_ack, m1_ack, grant); end
    tick(); mem_ack = 0; #1;
    checks++; if (grant !== 2'b00 || tmo !== 1'b0) begin errors++; $display("FAIL stray_after: grant %b tmo %b exp 00 0", grant, tmo); end
  endtask

  task automatic test_async_reset();
    m1_en = 1; m1_addr = 32'h77;
    tick(); #1;
    checks++; if (grant !== 2'b10 || mem_addr !== 32'h77) begin errors++; $display("FAIL ares_pre: grant %b addr %h exp 10 77", grant, mem_addr); end
    mem_ack = 1; m0_en = 1; #1;
    rst = 1; #1;
    checks++; if (grant !== 2'b00 || mem_en !== 1'b0 || m1_ack !== 1'b0 || mem_addr !== '0) begin errors++; $display("FAIL ares_now: grant %b en %b ack %b exp 00 0 0", grant, mem_en, m1_ack); end
    tick(); rst = 0; mem_ack = 0; #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL ares_idle: got %b exp 00", grant); end
    tick(); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL ares_tie: got %b exp 01", grant); end
    m0_en = 0; m1_en = 0; m1_addr = '0;
    tick(); tick();
  endtask

  task automatic test_watchdog();
    m0_en = 1; m0_addr = 32'h40;
    tick();
    repeat (7) tick();
    #1;
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL wd_early: got %b exp 0", tmo); end
    tick(); #1;
    checks++; if (tmo !== 1'b1 || grant !== 2'b01) begin errors++; $display("FAIL wd_fire: tmo %b grant %b exp 1 01", tmo, grant); end
    mem_ack = 1; #1;
    checks++; if (m0_ack !== 1'b1) begin errors++; $display("FAIL wd_ack: got %b exp 1", m0_ack); end
    tick(); mem_ack = 0; m0_en = 0;
    tick(); #1;
    checks++; if (tmo !== 1'b1 || grant !== 2'b00) begin errors++; $display("FAIL wd_sticky: tmo %b grant %b exp 1 00", tmo, grant); end
    rst = 1; #1;
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL wd_clear: got %b exp 0", tmo); end
    tick(); rst = 0; m0_addr = '0;
  endtask

  initial begin
    test_reset();
    test_tie();
    test_single_read();
    test_locked();
    test_stray_ack();
    test_async_reset();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
